conflict_monitor: RTL and testbench

CONFLICT_MONITOR -- requirements
Module: conflict_monitor

---
 rtl/conflict_monitor.sv | 220 ++++++++++++++++++++++
 tb/tb_conflict_monitor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conflict_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : conflict_monitor
//  Description : Safety monitor for a two-road traffic controller with a
//                pedestrian lamp. Decodes the controller's light codes into
//                an observed intersection state and checks each cycle for
//                illegal combinations, illegal transitions, short yellows,
//                stuck greens, an over-long startup and unsafe walk requests.
//                The first fault is latched until reset and forces the lamps
//                into a red flash that ignores the controller.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1  clock, rising edge
//    reset          in   1  synchronous, active-high reset
//    main_light_i   in   2  main code: 0 off, 1 green, 2 yellow, 3 red
//    side_light_i   in   2  side code, same encoding
//    walk_light_i   in   1  walk request for the pedestrian lamp
//    main_lamp_o    out  3  one-hot main lamp {red, yellow, green}
//    side_lamp_o    out  3  one-hot side lamp {red, yellow, green}
//    walk_lamp_o    out  1  pedestrian lamp
//    fault_o        out  1  latched fault indicator
//    fault_code_o   out  3  cause of the first fault, 0 = none
// ============================================================================
module conflict_monitor #(
    parameter int YEL_MIN     = 3,
    parameter int GRN_MAX     = 20,
    parameter int STARTUP_MAX = 8,
    parameter int FLASH_HALF  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] main_light_i,
    input  logic [1:0] side_light_i,
    input  logic       walk_light_i,
    output logic [2:0] main_lamp_o,
    output logic [2:0] side_lamp_o,
    output logic       walk_lamp_o,
    output logic       fault_o,
    output logic [2:0] fault_code_o
);

    typedef enum logic [2:0] {
        ST_OFF = 3'd0,
        ST_GR  = 3'd1,   // main green, side red
        ST_YR  = 3'd2,   // main yellow, side red
        ST_RG  = 3'd3,   // main red, side green
        ST_RY  = 3'd4,   // main red, side yellow
        ST_RR  = 3'd5,   // all red (walk phase)
        ST_ILL = 3'd6
    } state_t;

    localparam logic [2:0] FC_NONE      = 3'd0;
    localparam logic [2:0] FC_CONFLICT  = 3'd1;
    localparam logic [2:0] FC_WALK      = 3'd2;
    localparam logic [2:0] FC_SEQ       = 3'd3;
    localparam logic [2:0] FC_YEL_SHORT = 3'd4;
    localparam logic [2:0] FC_STUCK     = 3'd5;
    localparam logic [2:0] FC_STARTUP   = 3'd6;

    localparam logic [4:0] DWELL_MAX     = 5'd31;
    localparam logic [4:0] YEL_MIN_L     = 5'(YEL_MIN);
    localparam logic [4:0] GRN_MAX_L     = 5'(GRN_MAX);
    localparam logic [4:0] STARTUP_MAX_L = 5'(STARTUP_MAX);

    localparam int             FW          = $clog2(2 * FLASH_HALF);
    localparam logic [FW-1:0]  FLASH_ONE   = FW'(1);
    localparam logic [FW-1:0]  FLASH_ONLIM = FW'(FLASH_HALF);
    localparam logic [FW-1:0]  FLASH_LAST  = FW'(2 * FLASH_HALF - 1);

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    state_t          state_q, prev_q, state_d;
    logic [4:0]      dwell_q, dwell_d;
    logic [FW-1:0]   flash_q;
    logic            fault_q;
    logic [2:0]      code_q;
    logic [2:0]      main_lamp_q, side_lamp_q;
    logic            walk_lamp_q;

    logic            w_changed;
    logic            w_legal;
    logic            w_conflict;
    logic            w_walk_err;
    logic            w_seq_err;
    logic            w_yel_err;
    logic            w_stuck_err;
    logic            w_startup_err;
    logic [2:0]      w_code;

    // Previous state is kept for debug visibility only; no check depends on it.
    logic            unused_prev;
    assign unused_prev = ^prev_q;

    function automatic logic [2:0] lamp_decode(input logic [1:0] code);
        logic [2:0] lamp;
        case (code)
            2'd1:    lamp = 3'b001;
            2'd2:    lamp = 3'b010;
            2'd3:    lamp = 3'b100;
            default: lamp = 3'b000;
        endcase
        return lamp;
    endfunction

    // Observed state of the current input sample.
    always_comb begin
        state_d = ST_ILL;
        case ({main_light_i, side_light_i})
            4'b00_00: state_d = ST_OFF;
            4'b01_11: state_d = ST_GR;
            4'b10_11: state_d = ST_YR;
            4'b11_01: state_d = ST_RG;
            4'b11_10: state_d = ST_RY;
            4'b11_11: state_d = ST_RR;
            default:  state_d = ST_ILL;
        endcase
    end

    // Dwell including the current sample, so checks see the count that
    // will be registered this edge.
    always_comb begin
        w_changed = (state_d != state_q);
        if (w_changed) begin
            dwell_d = 5'd1;
        end else if (dwell_q == DWELL_MAX) begin
            dwell_d = dwell_q;
        end else begin
            dwell_d = dwell_q + 5'd1;
        end
    end

    always_comb begin
        w_legal = 1'b0;
        case (state_q)
            ST_OFF:  w_legal = (state_d == ST_GR);
            ST_GR:   w_legal = (state_d == ST_YR);
            ST_YR:   w_legal = (state_d == ST_RG) || (state_d == ST_RR);
            ST_RR:   w_legal = (state_d == ST_RG);
            ST_RG:   w_legal = (state_d == ST_RY);
            ST_RY:   w_legal = (state_d == ST_GR);
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_conflict    = (state_d == ST_ILL);
        w_walk_err    = walk_light_i && (state_d != ST_RR);
        // Moves into or out of an illegal pair are reported as conflicts.
        w_seq_err     = w_changed && !w_conflict && (state_q != ST_ILL) && !w_legal;
        w_yel_err     = w_changed && ((state_q == ST_YR) || (state_q == ST_RY))
                        && (dwell_q < YEL_MIN_L);
        w_stuck_err   = ((state_d == ST_GR) || (state_d == ST_RG)) && (dwell_d > GRN_MAX_L);
        w_startup_err = (state_d == ST_OFF) && (dwell_d > STARTUP_MAX_L);

        if (w_conflict) begin
            w_code = FC_CONFLICT;
        end else if (w_walk_err) begin
            w_code = FC_WALK;
        end else if (w_seq_err) begin
            w_code = FC_SEQ;
        end else if (w_yel_err) begin
            w_code = FC_YEL_SHORT;
        end else if (w_stuck_err) begin
            w_code = FC_STUCK;
        end else if (w_startup_err) begin
            w_code = FC_STARTUP;
        end else begin
            w_code = FC_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_OFF;
            prev_q      <= ST_OFF;
            dwell_q     <= '0;
            flash_q     <= '0;
            fault_q     <= 1'b0;
            code_q      <= FC_NONE;
            main_lamp_q <= LAMP_OFF;
            side_lamp_q <= LAMP_OFF;
            walk_lamp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= state_q;
            dwell_q <= dwell_d;

            if (fault_q) begin
                // flash_q is the phase shown on the next edge; the first
                // half of the period is lit.
                main_lamp_q <= (flash_q < FLASH_ONLIM) ? LAMP_RED : LAMP_OFF;
                side_lamp_q <= (flash_q < FLASH_ONLIM) ? LAMP_RED : LAMP_OFF;
                walk_lamp_q <= 1'b0;
                flash_q     <= (flash_q == FLASH_LAST) ? '0 : flash_q + FLASH_ONE;
            end else if (w_code != FC_NONE) begin
                // Fault edge shows phase 0 (lit) together with the flag.
                fault_q     <= 1'b1;
                code_q      <= w_code;
                main_lamp_q <= LAMP_RED;
                side_lamp_q <= LAMP_RED;
                walk_lamp_q <= 1'b0;
                flash_q     <= FLASH_ONE;
            end else begin
                main_lamp_q <= lamp_decode(main_light_i);
                side_lamp_q <= lamp_decode(side_light_i);
                walk_lamp_q <= walk_light_i;
            end
        end
    end

    assign main_lamp_o  = main_lamp_q;
    assign side_lamp_o  = side_lamp_q;
    assign walk_lamp_o  = walk_lamp_q;
    assign fault_o      = fault_q;
    assign fault_code_o = code_q;

endmodule
`default_nettype wire

// File: tb/tb_conflict_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conflict_monitor
//  Description : Self-checking bench for conflict_monitor. Directed scenarios
//                followed by randomized walks through the light sequence,
//                compared every cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conflict_monitor;

    localparam int YEL_MIN     = 3;
    localparam int GRN_MAX     = 20;
    localparam int STARTUP_MAX = 8;
    localparam int FLASH_HALF  = 4;

    // Model state ids: 0 OFF, 1 G_r, 2 Y_r, 3 R_g, 4 R_y, 5 R_r, 6 ILLEGAL
    localparam int S_OFF = 0, S_GR = 1, S_YR = 2, S_RG = 3, S_RY = 4, S_RR = 5, S_ILL = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] main_l = 2'd0;
    logic [1:0] side_l = 2'd0;
    logic       walk_l = 1'b0;
    logic [2:0] main_lamp, side_lamp, fault_code;
    logic       walk_lamp, fault;

    int checks = 0;
    int errors = 0;

    int st_main [6] = '{0, 1, 2, 3, 3, 3};
    int st_side [6] = '{0, 3, 3, 1, 2, 3};
    bit legal   [7][7];

    int         m_state, m_dwell, m_code, m_flashn;
    bit         m_fault;
    logic [2:0] e_main, e_side;
    logic       e_walk;

    conflict_monitor #(
        .YEL_MIN     (YEL_MIN),
        .GRN_MAX     (GRN_MAX),
        .STARTUP_MAX (STARTUP_MAX),
        .FLASH_HALF  (FLASH_HALF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .main_light_i (main_l),
        .side_light_i (side_l),
        .walk_light_i (walk_l),
        .main_lamp_o  (main_lamp),
        .side_lamp_o  (side_lamp),
        .walk_lamp_o  (walk_lamp),
        .fault_o      (fault),
        .fault_code_o (fault_code)
    );

    always #5 clk = ~clk;

    function automatic int classify(input logic [1:0] m, input logic [1:0] s);
        for (int i = 0; i < 6; i++) begin
            if (int'(m) == st_main[i] && int'(s) == st_side[i]) return i;
        end
        return S_ILL;
    endfunction

    function automatic logic [2:0] lamp_of(input logic [1:0] c);
        return (c == 2'd0) ? 3'b000 : 3'(1 << (int'(c) - 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "/main_lamp"}, 32'(main_lamp), 32'(e_main));
        check({tag, "/side_lamp"}, 32'(side_lamp), 32'(e_side));
        check({tag, "/walk_lamp"}, 32'(walk_lamp), 32'(e_walk));
        check({tag, "/fault"},     32'(fault),     32'(m_fault));
        check({tag, "/code"},      32'(fault_code), 32'(m_code));
    endtask

    task automatic model_reset();
        m_state = S_OFF; m_dwell = 0; m_fault = 0; m_code = 0; m_flashn = 0;
        e_main = 3'b000; e_side = 3'b000; e_walk = 1'b0;
    endtask

    task automatic model_update(input logic [1:0] m, input logic [1:0] s, input logic w);
        int obs, nd, c;
        bit moved;
        obs   = classify(m, s);
        moved = (obs != m_state);
        nd    = moved ? 1 : ((m_dwell + 1 > 31) ? 31 : m_dwell + 1);
        c = 0;
        if (obs == S_ILL) c = 1;
        else if (w && obs != S_RR) c = 2;
        else if (moved && m_state != S_ILL && !legal[m_state][obs]) c = 3;
        else if (moved && (m_state == S_YR || m_state == S_RY) && m_dwell < YEL_MIN) c = 4;
        else if ((obs == S_GR || obs == S_RG) && nd > GRN_MAX) c = 5;
        else if (obs == S_OFF && nd > STARTUP_MAX) c = 6;
        if (m_fault) begin
            m_flashn++;
        end else if (c != 0) begin
            m_fault = 1; m_code = c; m_flashn = 0;
        end
        m_state = obs;
        m_dwell = nd;
        if (m_fault) begin
            e_main = ((m_flashn % (2 * FLASH_HALF)) < FLASH_HALF) ? 3'b100 : 3'b000;
            e_side = e_main;
            e_walk = 1'b0;
        end else begin
            e_main = lamp_of(m);
            e_side = lamp_of(s);
            e_walk = w;
        end
    endtask

    task automatic step(input logic [1:0] m, input logic [1:0] s, input logic w, input string tag);
        main_l = m; side_l = s; walk_l = w;
        @(posedge clk);
        #1;
        model_update(m, s, w);
        check_outputs(tag);
    endtask

    task automatic step_st(input int st, input logic w, input string tag);
        step(2'(st_main[st]), 2'(st_side[st]), w, tag);
    endtask

    task automatic hold(input int st, input logic w, input int n, input string tag);
        for (int i = 0; i < n; i++) step_st(st, w, tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; main_l = 2'd0; side_l = 2'd0; walk_l = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_outputs(tag);
        reset = 1'b0;
    endtask

    initial begin
        int cur, nxt, dur;
        logic w;
        legal[S_OFF][S_GR] = 1; legal[S_GR][S_YR] = 1; legal[S_YR][S_RG] = 1;
        legal[S_YR][S_RR]  = 1; legal[S_RR][S_RG] = 1; legal[S_RG][S_RY] = 1;
        legal[S_RY][S_GR]  = 1;

        // Legal cycle
        do_reset("rst0");
        hold(S_OFF, 0, 2, "legal_off");
        step_st(S_GR, 0, "legal_gr_first");
        check("legal_gr_main_001", 32'(main_lamp), 32'd1);
        check("legal_gr_side_100", 32'(side_lamp), 32'd4);
        hold(S_GR, 0, 9, "legal_gr");
        hold(S_YR, 0, 3, "legal_yr");
        hold(S_RG, 0, 6, "legal_rg");
        hold(S_RY, 0, 3, "legal_ry");
        hold(S_GR, 0, 2, "legal_gr2");
        check("legal_no_fault", 32'(fault), 32'd0);

        // Walk path
        do_reset("rst1");
        hold(S_OFF, 0, 1, "walk_off");
        hold(S_GR, 0, 3, "walk_gr");
        hold(S_YR, 0, 3, "walk_yr");
        hold(S_RR, 1, 4, "walk_rr");
        check("walk_lamp_on", 32'(walk_lamp), 32'd1);
        hold(S_RG, 0, 2, "walk_rg");
        check("walk_lamp_off", 32'(walk_lamp), 32'd0);
        check("walk_no_fault", 32'(fault), 32'd0);

        // Conflict and flash
        do_reset("rst2");
        hold(S_OFF, 0, 2, "cf_off");
        hold(S_GR, 0, 3, "cf_gr");
        step(2'd1, 2'd1, 1'b0, "cf_pair");
        check("cf_code_1", 32'(fault_code), 32'd1);
        check("cf_lamp_red", 32'(main_lamp), 32'd4);
        hold(S_GR, 0, 3, "cf_flash_on");
        check("cf_still_red", 32'(side_lamp), 32'd4);
        hold(S_GR, 1, 1, "cf_flash_off");
        check("cf_dark", 32'(main_lamp), 32'd0);
        hold(S_GR, 0, 12, "cf_flash_more");

        // First-fault latch
        do_reset("rst3");
        hold(S_OFF, 0, 1, "ff_off");
        hold(S_GR, 0, 3, "ff_gr");
        hold(S_YR, 0, 2, "ff_yr");
        step_st(S_RG, 0, "ff_rg");
        check("ff_code_4", 32'(fault_code), 32'd4);
        hold(S_RG, 1, 3, "ff_walk");
        check("ff_code_stays_4", 32'(fault_code), 32'd4);

        // Stuck green, then reset mid-flash
        do_reset("rst4");
        hold(S_OFF, 0, 2, "st_off");
        hold(S_GR, 0, 20, "st_gr20");
        check("st_no_fault_at_20", 32'(fault), 32'd0);
        step_st(S_GR, 0, "st_gr21");
        check("st_code_5", 32'(fault_code), 32'd5);
        hold(S_GR, 0, 4, "st_gr25");
        do_reset("st_reset");
        check("st_cleared", 32'(fault), 32'd0);

        // Startup and sequence
        hold(S_OFF, 0, 8, "su_off8");
        check("su_no_fault_at_8", 32'(fault), 32'd0);
        step_st(S_OFF, 0, "su_off9");
        check("su_code_6", 32'(fault_code), 32'd6);
        do_reset("rst5");
        hold(S_OFF, 0, 1, "sq_off");
        hold(S_GR, 0, 1, "sq_gr");
        step_st(S_RG, 0, "sq_rg");
        check("sq_code_3", 32'(fault_code), 32'd3);

        // Randomized sequences with occasional illegal pairs and walk faults
        for (int r = 0; r < 14; r++) begin
            do_reset("rnd_rst");
            hold(S_OFF, 0, $urandom_range(1, 10), "rnd_off");
            cur = S_OFF;
            for (int k = 0; k < 12; k++) begin
                case (cur)
                    S_OFF:   nxt = S_GR;
                    S_GR:    nxt = S_YR;
                    S_YR:    nxt = ($urandom_range(0, 1) == 1) ? S_RR : S_RG;
                    S_RR:    nxt = S_RG;
                    S_RG:    nxt = S_RY;
                    default: nxt = S_GR;
                endcase
                if (nxt == S_YR || nxt == S_RY) dur = $urandom_range(1, 5);
                else if (nxt == S_RR) dur = $urandom_range(1, 4);
                else dur = $urandom_range(1, 23);
                for (int d = 0; d < dur; d++) begin
                    if ($urandom_range(0, 59) == 0) begin
                        step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                             1'($urandom_range(0, 1)), "rnd_pair");
                    end else begin
                        if (nxt == S_RR) w = 1'($urandom_range(0, 1));
                        else w = ($urandom_range(0, 79) == 0);
                        step_st(nxt, w, "rnd_seq");
                    end
                end
                cur = nxt;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
